// File: rtl/pong_game_ctrl_if.sv
// Bundles the ball-side flags, player controls and the score/status outputs
// that the Pong round controller exchanges with the rest of the datapath.
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               in_ani_stb;
  logic               in_serve;
  logic               in_pause;
  logic               in_left_score;
  logic               in_right_score;
  logic               out_start;
  logic               out_animate;
  logic               out_ball_reset;
  logic [SCORE_W-1:0] out_left_points;
  logic [SCORE_W-1:0] out_right_points;
  logic               out_game_over;
  logic               out_winner;
  logic [1:0]         out_state;

  modport master (
    output in_ani_stb, in_serve, in_pause, in_left_score, in_right_score,
    input  out_start, out_animate, out_ball_reset, out_left_points,
           out_right_points, out_game_over, out_winner, out_state
  );

  modport slave (
    input  in_ani_stb, in_serve, in_pause, in_left_score, in_right_score,
    output out_start, out_animate, out_ball_reset, out_left_points,
           out_right_points, out_game_over, out_winner, out_state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong round/score controller: serve, rally, inter-point delay and game-over
// sequencing driven by the ball's score flags.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 5,
  parameter int DELAY_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  pong_game_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DELAY = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int                 CNT_W      = 10;
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   LAST_FRAME = CNT_W'(DELAY_FRAMES - 1);

  // Scores never climb past the winning value, even if a stray edge slips in.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic en);
    if (en && (v < WIN_S)) begin
      return v + SCORE_W'(1);
    end else begin
      return v;
    end
  endfunction

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [SCORE_W-1:0] left_r;
  logic [SCORE_W-1:0] right_r;
  logic               serve_q_r;
  logic               lscore_q_r;
  logic               rscore_q_r;
  logic               start_r;
  logic               ball_reset_r;
  logic               game_over_r;
  logic               winner_r;

  logic               serve_rise_s;
  logic               lrise_s;
  logic               rrise_s;
  logic [SCORE_W-1:0] left_next_s;
  logic [SCORE_W-1:0] right_next_s;
  logic               left_win_s;
  logic               right_win_s;

  // Edge detection and post-increment score values used by the PLAY decision.
  always_comb begin
    serve_rise_s = bus.in_serve & ~serve_q_r;
    lrise_s      = bus.in_left_score & ~lscore_q_r;
    rrise_s      = bus.in_right_score & ~rscore_q_r;
    left_next_s  = sat_inc(left_r, lrise_s);
    right_next_s = sat_inc(right_r, rrise_s);
    left_win_s   = (left_next_s == WIN_S);
    right_win_s  = (right_next_s == WIN_S);
  end

  // Round sequencer: state, scores, delay counter and registered pulses.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      left_r       <= '0;
      right_r      <= '0;
      serve_q_r    <= 1'b0;
      lscore_q_r   <= 1'b0;
      rscore_q_r   <= 1'b0;
      start_r      <= 1'b0;
      ball_reset_r <= 1'b0;
      game_over_r  <= 1'b0;
      winner_r     <= 1'b0;
    end else begin
      serve_q_r    <= bus.in_serve;
      lscore_q_r   <= bus.in_left_score;
      rscore_q_r   <= bus.in_right_score;
      start_r      <= 1'b0;
      ball_reset_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (serve_rise_s) begin
            start_r <= 1'b1;
            state_r <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (lrise_s || rrise_s) begin
            left_r  <= left_next_s;
            right_r <= right_next_s;
            // A simultaneous win is awarded to the left player.
            if (left_win_s) begin
              state_r     <= ST_OVER;
              game_over_r <= 1'b1;
              winner_r    <= 1'b0;
            end else if (right_win_s) begin
              state_r     <= ST_OVER;
              game_over_r <= 1'b1;
              winner_r    <= 1'b1;
            end else begin
              state_r <= ST_DELAY;
              cnt_r   <= '0;
            end
          end
        end
        ST_DELAY: begin
          if (bus.in_ani_stb && !bus.in_pause) begin
            if (cnt_r == LAST_FRAME) begin
              cnt_r   <= '0;
              start_r <= 1'b1;
              state_r <= ST_PLAY;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        ST_OVER: begin
          if (serve_rise_s) begin
            ball_reset_r <= 1'b1;
            left_r       <= '0;
            right_r      <= '0;
            game_over_r  <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_start        = start_r;
  assign bus.out_ball_reset   = ball_reset_r;
  assign bus.out_animate      = (state_r == ST_PLAY) & ~bus.in_pause;
  assign bus.out_left_points  = left_r;
  assign bus.out_right_points = right_r;
  assign bus.out_game_over    = game_over_r;
  assign bus.out_winner       = winner_r;
  assign bus.out_state        = state_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table plus point-by-point
// sequences, with expectations queued on drive and checked after each edge.
module tb_pong_game_ctrl;

  localparam int WIN = 5;
  localparam int DF  = 4;
  localparam int SW  = 4;

  typedef struct packed {
    logic          start;
    logic          brst;
    logic          anim;
    logic [SW-1:0] lp;
    logic [SW-1:0] rp;
    logic          go;
    logic          win;
    logic [1:0]    st;
  } exp_t;

  typedef struct {
    string      name;
    logic [5:0] in_v;   // {reset, serve, pause, ani_stb, left_flag, right_flag}
    exp_t       e;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   exp_l;
  int   exp_r;
  logic exp_win;
  exp_t sb_q[$];
  vec_t tbl[11];

  pong_game_ctrl_if #(.SCORE_W(SW)) pif ();

  pong_game_ctrl #(
    .WIN_SCORE   (WIN),
    .DELAY_FRAMES(DF),
    .SCORE_W     (SW)
  ) dut (
    .in_clock(clk),
    .in_reset(rst),
    .bus     (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mke(logic start, logic brst, logic anim, int lp, int rp,
                               logic go, logic win, int st);
    exp_t e;
    e.start = start; e.brst = brst; e.anim = anim;
    e.lp = SW'(lp); e.rp = SW'(rp);
    e.go = go; e.win = win; e.st = 2'(st);
    return e;
  endfunction

  // Expected outputs using the bench's running score/winner model.
  function automatic exp_t ex(logic start, logic brst, logic anim, int st, logic go);
    return mke(start, brst, anim, exp_l, exp_r, go, exp_win, st);
  endfunction

  function automatic vec_t mkv(string n, logic [5:0] in_v, exp_t e);
    vec_t v;
    v.name = n; v.in_v = in_v; v.e = e;
    return v;
  endfunction

  task automatic step(input string name, input logic [5:0] in_v, input exp_t e);
    exp_t got;
    exp_t want;
    @(negedge clk);
    {rst, pif.in_serve, pif.in_pause, pif.in_ani_stb, pif.in_left_score,
     pif.in_right_score} = in_v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = {pif.out_start, pif.out_ball_reset, pif.out_animate, pif.out_left_points,
           pif.out_right_points, pif.out_game_over, pif.out_winner, pif.out_state};
    want = sb_q.pop_front();
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got start=%0b brst=%0b anim=%0b L=%0d R=%0d over=%0b win=%0b st=%0d, expected start=%0b brst=%0b anim=%0b L=%0d R=%0d over=%0b win=%0b st=%0d",
               name, got.start, got.brst, got.anim, got.lp, got.rp, got.go, got.win, got.st,
               want.start, want.brst, want.anim, want.lp, want.rp, want.go, want.win, want.st);
    end
  endtask

  // One point from PLAY: through the delay and re-serve, or into OVER.
  task automatic score_point(input string name, input logic l, input logic r);
    logic [5:0] flags;
    flags = {4'b0000, l, r};
    exp_l += int'(l);
    exp_r += int'(r);
    if (exp_l == WIN || exp_r == WIN) begin
      exp_win = (exp_l == WIN) ? 1'b0 : 1'b1;
      step({name, "_over"}, flags, ex(1'b0, 1'b0, 1'b0, 3, 1'b1));
    end else begin
      step({name, "_pt"}, flags, ex(1'b0, 1'b0, 1'b0, 2, 1'b0));
      for (int i = 0; i < DF - 1; i++) begin
        step({name, "_wait"}, flags | 6'b000100, ex(1'b0, 1'b0, 1'b0, 2, 1'b0));
      end
      step({name, "_reserve"}, flags | 6'b000100, ex(1'b1, 1'b0, 1'b1, 1, 1'b0));
      step({name, "_rally"}, 6'b000000, ex(1'b0, 1'b0, 1'b1, 1, 1'b0));
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    exp_l = 0; exp_r = 0; exp_win = 1'b0;
    rst = 1'b1;
    pif.in_serve = 1'b0; pif.in_pause = 1'b0; pif.in_ani_stb = 1'b0;
    pif.in_left_score = 1'b0; pif.in_right_score = 1'b0;

    // Serve, one left point, paused delay with an ignored serve, re-serve.
    tbl[0]  = mkv("serve_start",   6'b010000, mke(1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1));
    tbl[1]  = mkv("serve_held",    6'b010000, mke(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1));
    tbl[2]  = mkv("pause_play",    6'b001000, mke(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1));
    tbl[3]  = mkv("left_point",    6'b000010, mke(1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 2));
    tbl[4]  = mkv("delay_stb1",    6'b000110, mke(1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 2));
    tbl[5]  = mkv("delay_paused",  6'b001110, mke(1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 2));
    tbl[6]  = mkv("delay_stb2",    6'b000110, mke(1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 2));
    tbl[7]  = mkv("delay_serve",   6'b010010, mke(1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 2));
    tbl[8]  = mkv("delay_stb3",    6'b000110, mke(1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 2));
    tbl[9]  = mkv("delay_reserve", 6'b000110, mke(1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1));
    tbl[10] = mkv("rally_again",   6'b000000, mke(1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1));

    step("reset_a", 6'b100000, mke(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0));
    step("reset_b", 6'b100000, mke(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0));
    step("idle",    6'b000000, mke(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0));

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].name, tbl[i].in_v, tbl[i].e);
    end
    exp_l = 1;

    // Right wins 5-1; later edges in OVER are ignored; serve clears.
    for (int k = 0; k < WIN; k++) begin
      score_point("right", 1'b0, 1'b1);
    end
    step("over_drop",   6'b000000, ex(1'b0, 1'b0, 1'b0, 3, 1'b1));
    step("over_ignore", 6'b000011, ex(1'b0, 1'b0, 1'b0, 3, 1'b1));
    step("over_quiet",  6'b000000, ex(1'b0, 1'b0, 1'b0, 3, 1'b1));
    exp_l = 0; exp_r = 0;
    step("over_clear",  6'b010000, ex(1'b0, 1'b1, 1'b0, 0, 1'b0));
    step("idle_after",  6'b000000, ex(1'b0, 1'b0, 1'b0, 0, 1'b0));

    // Climb to 4-4, then both flags rise together: left takes the tie.
    step("tie_serve", 6'b010000, ex(1'b1, 1'b0, 1'b1, 1, 1'b0));
    step("tie_rally", 6'b000000, ex(1'b0, 1'b0, 1'b1, 1, 1'b0));
    for (int k = 0; k < WIN - 1; k++) begin
      score_point("tie_l", 1'b1, 1'b0);
      score_point("tie_r", 1'b0, 1'b1);
    end
    score_point("tie_both", 1'b1, 1'b1);
    step("tie_hold", 6'b000000, ex(1'b0, 1'b0, 1'b0, 3, 1'b1));
    exp_l = 0; exp_r = 0;
    step("tie_clear", 6'b010000, ex(1'b0, 1'b1, 1'b0, 0, 1'b0));
    step("tie_idle",  6'b000000, ex(1'b0, 1'b0, 1'b0, 0, 1'b0));

    // Reset in the middle of the delay at 3-2, then a fresh rally.
    step("mid_serve", 6'b010000, ex(1'b1, 1'b0, 1'b1, 1, 1'b0));
    step("mid_rally", 6'b000000, ex(1'b0, 1'b0, 1'b1, 1, 1'b0));
    score_point("m1", 1'b1, 1'b0);
    score_point("m2", 1'b0, 1'b1);
    score_point("m3", 1'b1, 1'b0);
    score_point("m4", 1'b0, 1'b1);
    exp_l = 3;
    step("mid_point", 6'b000010, ex(1'b0, 1'b0, 1'b0, 2, 1'b0));
    step("mid_stb",   6'b000110, ex(1'b0, 1'b0, 1'b0, 2, 1'b0));
    exp_l = 0; exp_r = 0; exp_win = 1'b0;
    step("mid_reset",   6'b100010, ex(1'b0, 1'b0, 1'b0, 0, 1'b0));
    step("post_flag",   6'b000010, ex(1'b0, 1'b0, 1'b0, 0, 1'b0));
    step("fresh_serve", 6'b010000, ex(1'b1, 1'b0, 1'b1, 1, 1'b0));
    step("fresh_rally", 6'b000000, ex(1'b0, 1'b0, 1'b1, 1, 1'b0));
    score_point("fresh", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Round/score controller directly downstream of the ball block.
- Consumes the ball's left/right score flags and keeps the match score.
- Drives the ball's in_start and in_animate inputs and a ball-recentre pulse.
- Runs serve, rally, inter-point delay and game-over sequencing for the Pong datapath.

Parameters:
- WIN_SCORE, 5: points needed to win the match (1..15).
- DELAY_FRAMES, 60: in_ani_stb pulses to wait between a point and the automatic re-serve (1..1023).
- SCORE_W, 4: width of the score counters.

Ports:
- in_clock  input  1  base clock
- in_reset  input  1  synchronous, active-high reset
- in_ani_stb  input  1  one-cycle animation strobe, once per frame
- in_serve  input  1  serve/restart button, level, already debounced
- in_pause  input  1  level; freezes animation while high
- in_left_score  input  1  ball flag: left player scored (level, held until next start)
- in_right_score  input  1  ball flag: right player scored (level, held until next start)
- out_start  output  1  one-cycle pulse to ball in_start
- out_animate  output  1  to ball in_animate
- out_ball_reset  output  1  one-cycle pulse, recentres the ball
- out_left_points  output  SCORE_W  left score
- out_right_points  output  SCORE_W  right score
- out_game_over  output  1  high in OVER state
- out_winner  output  1  0 = left won, 1 = right won; valid when out_game_over = 1
- out_state  output  2  IDLE = 0, PLAY = 1, DELAY = 2, OVER = 3

Behaviour:
- Reset: single clock domain, all registers synchronous to in_clock. While in_reset is high:
  - state = IDLE, both scores = 0, delay counter = 0;
  - serve/score edge-history registers = 0;
  - out_start, out_ball_reset, out_game_over, out_winner = 0.
- Reset mid-operation: abandons any state and counter immediately.
- Edge detection:
  - serve_rise = in_serve & ~serve_q.
  - lrise / rrise are the same construction on in_left_score / in_right_score.
  - History registers update every cycle.
- out_animate = (state == PLAY) & ~in_pause. Combinational from registered state.
- IDLE: serve_rise -> next cycle out_start = 1 for exactly one cycle, state = PLAY.
- PLAY, score edges:
  - lrise increments left; rrise increments right.
  - If both rise in the same cycle, both increment.
  - Score edges outside PLAY are ignored.
- PLAY, transition on any edge, evaluated on the post-increment values:
  - if left reaches WIN_SCORE or right reaches WIN_SCORE -> OVER;
  - if both reach it together, winner = left (tie goes to left);
  - otherwise -> DELAY with delay counter cleared.
- PLAY, other rules:
  - in_pause has no effect on state or scores; it only drops out_animate.
  - serve_rise is ignored in PLAY.
- DELAY:
  - Counter increments on each in_ani_stb.
  - When counter == DELAY_FRAMES - 1 and in_ani_stb = 1: out_start pulses one cycle, state = PLAY.
  - in_pause freezes the counter.
  - serve_rise is ignored.
- OVER:
  - out_game_over = 1; out_winner held.
  - Scores hold at final values and saturate (never exceed WIN_SCORE).
  - serve_rise -> next cycle: out_ball_reset = 1 for one cycle, both scores cleared, out_game_over = 0, state = IDLE.
- Output registering: out_start and out_ball_reset are registered, one-cycle pulses, never both high together.
- Score width: counters are SCORE_W bits; WIN_SCORE must be < 2^SCORE_W.

Test Plan:
- Reset, then in_serve pulse: out_start high exactly one cycle, 1 clock after the serve edge; out_state = 1; out_animate = 1.
- PLAY, in_left_score rises and stays high 100 cycles: out_left_points goes 0 -> 1 once; out_state = 2; out_animate = 0.
- DELAY_FRAMES = 4: after 4 in_ani_stb pulses, out_start pulses once on the 4th strobe's following cycle, out_state = 1. Holding in_pause for 2 strobes delays this by 2 strobes.
- Right scores 5 times (WIN_SCORE = 5): out_state = 3, out_game_over = 1, out_winner = 1, out_right_points = 5. Further score edges leave it at 5.
- Both score flags rise in the same cycle at 4–4: both scores = 5, out_winner = 0. Then in_serve: out_ball_reset pulses one cycle, scores = 0, out_state = 0.
- in_reset asserted for one cycle mid-DELAY at score 3–2: next cycle scores = 0, out_state = 0, out_start = 0. A subsequent in_serve starts a fresh rally.
